// File: rtl/nios2_cpu_debug_pkg.sv
// Shared types and defaults for the Nios II debug scan master.
// State encoding, IR opcodes and default widths.
package nios2_cpu_debug_pkg;

   localparam int DEF_DR_WIDTH = 38;
   localparam int DEF_IR_WIDTH = 2;
   localparam int DEF_TCK_DIV  = 2;

   localparam logic [1:0] IR_OCIMEM    = 2'd0;
   localparam logic [1:0] IR_TRACEMEM  = 2'd1;
   localparam logic [1:0] IR_BREAK     = 2'd2;
   localparam logic [1:0] IR_TRACECTRL = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UIR,
      ST_CDR,
      ST_SHIFT,
      ST_UDR,
      ST_RTI,
      ST_RESP
   } scan_state_e;

   // tck only runs while a scan is actually on the wire
   function automatic logic scan_active(input scan_state_e s);
      return (s != ST_IDLE) && (s != ST_RESP);
   endfunction

endpackage

// File: rtl/nios2_cpu_debug_scan_tckgen.sv
// Divided scan clock: tck low for the first half-period, high for the
// second, with one-cycle strobes on the cycle before each edge.
module nios2_cpu_debug_scan_tckgen #(
   parameter int TCK_DIV = 2
) (
   input  logic clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_tck,
   output logic o_tck_rise,
   output logic o_tck_fall
);

   localparam int CW = (TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
   localparam logic [CW-1:0] HALF = CW'(TCK_DIV - 1);
   localparam logic [CW-1:0] LAST = CW'(2 * TCK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_tck;
   logic          w_run;

   assign w_run      = i_en && !i_rst;
   assign o_tck_rise = w_run && (r_cnt == HALF);
   assign o_tck_fall = w_run && (r_cnt == LAST);
   assign o_tck      = r_tck;

   always_ff @(posedge clk) begin
      if (!w_run) begin
         r_cnt <= '0;
         r_tck <= 1'b0;
      end else begin
         r_cnt <= o_tck_fall ? '0 : r_cnt + CW'(1);
         if (o_tck_rise)
            r_tck <= 1'b1;
         else if (o_tck_fall)
            r_tck <= 1'b0;
      end
   end

endmodule

// File: rtl/nios2_cpu_cpu_debug_scan_master.sv
// Virtual-JTAG scan initiator: turns (IR, DR) commands into UIR/CDR/SDR/
// UDR/RTI strobes, divided tck and tdi, and returns captured tdo.
module nios2_cpu_cpu_debug_scan_master
   import nios2_cpu_debug_pkg::*;
#(
   parameter int DR_WIDTH = DEF_DR_WIDTH,
   parameter int IR_WIDTH = DEF_IR_WIDTH,
   parameter int TCK_DIV  = DEF_TCK_DIV
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti,
   output logic                busy
);

   localparam int BW = $clog2(DR_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DR_WIDTH - 1);

   scan_state_e         r_state;
   scan_state_e         w_next;
   logic [BW-1:0]       r_bit;
   logic [DR_WIDTH-1:0] r_tx;
   logic [DR_WIDTH-1:0] r_rx;
   logic                w_rise;
   logic                w_fall;
   logic                w_en;

   assign w_en = scan_active(r_state);

   nios2_cpu_debug_scan_tckgen #(
      .TCK_DIV (TCK_DIV)
   ) u_tckgen (
      .clk        (clk),
      .i_rst      (reset),
      .i_en       (w_en),
      .o_tck      (vji_tck),
      .o_tck_rise (w_rise),
      .o_tck_fall (w_fall)
   );

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // every scan state advances only on the cycle tck falls
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (cmd_valid) w_next = ST_UIR;
         ST_UIR:   if (w_fall) w_next = ST_CDR;
         ST_CDR:   if (w_fall) w_next = ST_SHIFT;
         ST_SHIFT: if (w_fall && r_bit == LAST_BIT) w_next = ST_UDR;
         ST_UDR:   if (w_fall) w_next = ST_RTI;
         ST_RTI:   if (w_fall) w_next = ST_RESP;
         ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_dr     <= '0;
         rsp_ir_out <= '0;
         vji_tdi    <= 1'b0;
         vji_ir_in  <= '0;
         vji_uir    <= 1'b0;
         vji_cdr    <= 1'b0;
         vji_sdr    <= 1'b0;
         vji_udr    <= 1'b0;
         vji_rti    <= 1'b0;
         r_bit      <= '0;
         r_tx       <= '0;
         r_rx       <= '0;
      end else begin
         cmd_ready <= (w_next == ST_IDLE);
         busy      <= (w_next != ST_IDLE);
         rsp_valid <= (w_next == ST_RESP);
         vji_uir   <= (w_next == ST_UIR);
         vji_cdr   <= (w_next == ST_CDR);
         vji_sdr   <= (w_next == ST_SHIFT);
         vji_udr   <= (w_next == ST_UDR);
         vji_rti   <= (w_next == ST_RTI);

         if (r_state == ST_IDLE && cmd_valid) begin
            vji_ir_in <= cmd_ir;
            r_tx      <= cmd_dr;
         end

         // tdi changes at period start, together with tck falling
         if (w_fall) begin
            if (w_next == ST_SHIFT) begin
               vji_tdi <= r_tx[0];
               r_tx    <= r_tx >> 1;
            end else begin
               vji_tdi <= 1'b0;
            end
         end

         if (w_fall && r_state == ST_CDR)
            r_bit <= '0;
         else if (w_fall && r_state == ST_SHIFT)
            r_bit <= r_bit + BW'(1);

         if (w_rise && r_state == ST_SHIFT)
            r_rx <= {vji_tdo, r_rx[DR_WIDTH-1:1]};

         if (w_rise && r_state == ST_UIR)
            rsp_ir_out <= vji_ir_out;

         if (w_fall && r_state == ST_RTI)
            rsp_dr <= r_rx;
      end
   end

endmodule

// File: tb/tb_nios2_cpu_cpu_debug_scan_master.sv
// Randomized self-checking bench for the debug scan master, with a
// second instance at TCK_DIV=1.
module tb_nios2_cpu_cpu_debug_scan_master;

   localparam int DW = 38;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
   logic [IW-1:0] cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
   logic [DW-1:0] cmd_dr, rsp_dr;
   logic          vji_tck, vji_tdi, vji_tdo;
   logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, busy;

   logic          cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1;
   logic [IW-1:0] cmd_ir1, rsp_ir_out1, vji_ir_in1, vji_ir_out1;
   logic [DW-1:0] cmd_dr1, rsp_dr1;
   logic          vji_tck1, vji_tdi1, vji_tdo1;
   logic          vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1, busy1;

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            mon_err = 0;
   int            sdr_rises = 0;
   int            last_acc = 0;
   int            acc_gap = 0;
   logic [DW-1:0] tdi_seen;
   logic [DW-1:0] pat;
   logic [IW-1:0] cur_ir;
   bit            loop_mode;
   logic          prev_tck;
   int            prev_code;
   int            seq[$];
   logic [4:0]    strb;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign strb    = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
   assign vji_tdo = loop_mode ? vji_tdi : pat[(sdr_rises < DW) ? sdr_rises : 0];

   nios2_cpu_cpu_debug_scan_master u_dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
      .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
      .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
      .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
      .vji_udr(vji_udr), .vji_rti(vji_rti), .busy(busy)
   );

   nios2_cpu_cpu_debug_scan_master #(.TCK_DIV(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_ir(cmd_ir1), .cmd_dr(cmd_dr1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_dr(rsp_dr1), .rsp_ir_out(rsp_ir_out1),
      .vji_tck(vji_tck1), .vji_tdi(vji_tdi1), .vji_tdo(vji_tdo1),
      .vji_ir_in(vji_ir_in1), .vji_ir_out(vji_ir_out1),
      .vji_uir(vji_uir1), .vji_cdr(vji_cdr1), .vji_sdr(vji_sdr1),
      .vji_udr(vji_udr1), .vji_rti(vji_rti1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bus monitor: strobe exclusivity, idle quietness, strobe order,
   // tdi as seen on each SDR tck rise.
   always @(negedge clk) begin
      if ($countones(strb) > 1) mon_err++;
      if (!busy && (strb != 5'b0 || vji_tck || vji_tdi)) mon_err++;
      if (!vji_sdr && vji_tdi) mon_err++;
      if (busy && vji_ir_in !== cur_ir) mon_err++;
      if (strb != 5'b0) begin
         int code;
         code = vji_uir ? 1 : vji_cdr ? 2 : vji_sdr ? 3 : vji_udr ? 4 : 5;
         if (code != prev_code) seq.push_back(code);
         prev_code = code;
      end else begin
         prev_code = 0;
      end
      if (vji_tck && !prev_tck && vji_sdr) begin
         sdr_rises++;
         tdi_seen = {vji_tdi, tdi_seen[DW-1:1]};
      end
      prev_tck = vji_tck;
   end

   task automatic run_scan(input logic [IW-1:0] ir, input logic [DW-1:0] dr,
                           input logic [IW-1:0] iro, input bit loop,
                           input int hold, input bit keep);
      int            k;
      int            err;
      bit            ok;
      logic [DW-1:0] exp_dr;
      logic [DW-1:0] snap;
      cur_ir     = ir;
      cmd_ir     = ir;
      cmd_dr     = dr;
      vji_ir_out = iro;
      loop_mode  = loop;
      pat        = DW'({$urandom, $urandom});
      exp_dr     = loop ? dr : pat;
      sdr_rises  = 0;
      tdi_seen   = '0;
      seq.delete();
      cmd_valid  = 1'b1;
      k = 0;
      while (!cmd_ready && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("cmd_ready", 64'(cmd_ready), 64'(1));
      @(negedge clk);
      acc_gap  = cyc - last_acc;
      last_acc = cyc;
      if (!keep) cmd_valid = 1'b0;
      chk("uir_at_t1", 64'(vji_uir), 64'(1));
      chk("ir_in", 64'(vji_ir_in), 64'(ir));
      k = 1;
      while (!rsp_valid && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("latency", 64'(k), 64'(1 + (DW + 4) * 4));
      chk("rsp_dr", 64'(rsp_dr), 64'(exp_dr));
      chk("rsp_ir_out", 64'(rsp_ir_out), 64'(iro));
      chk("sdr_rises", 64'(sdr_rises), 64'(DW));
      chk("tdi_bits", 64'(tdi_seen), 64'(dr));
      ok = (seq.size() == 5);
      if (ok) foreach (seq[i]) if (seq[i] != i + 1) ok = 1'b0;
      chk("strobe_order", 64'(ok), 64'(1));
      snap = rsp_dr;
      err = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_dr !== snap || cmd_ready || strb != 5'b0)
            err++;
      end
      chk("backpressure", 64'(err), 64'(0));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("idle_after", 64'({cmd_ready, rsp_valid, busy}), 64'(3'b100));
   endtask

   initial begin
      int            k;
      int            err;
      logic [DW-1:0] d;
      reset       = 1'b1;
      cmd_valid   = 1'b0;
      cmd_ir      = '0;
      cmd_dr      = '0;
      rsp_ready   = 1'b0;
      vji_ir_out  = '0;
      cur_ir      = '0;
      loop_mode   = 1'b1;
      pat         = '0;
      tdi_seen    = '0;
      prev_tck    = 1'b0;
      prev_code   = 0;
      cmd_valid1  = 1'b0;
      cmd_ir1     = '0;
      cmd_dr1     = '0;
      rsp_ready1  = 1'b0;
      vji_ir_out1 = '0;
      vji_tdo1    = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(cmd_ready), 64'(1));
      chk("rst_ctl", 64'({busy, rsp_valid, vji_tck, vji_tdi, strb}), 64'(0));
      chk("rst_rsp_dr", 64'(rsp_dr), 64'(0));
      chk("rst_ir", 64'({rsp_ir_out, vji_ir_in}), 64'(0));
      chk("rst_ready1", 64'(cmd_ready1), 64'(1));
      reset = 1'b0;
      @(negedge clk);

      run_scan(2'd2, 38'h2A_5A5A_5A5A, 2'b11, 1'b1, 0, 1'b0);
      run_scan(2'd1, DW'({$urandom, $urandom}), 2'b01, 1'b0, 50, 1'b0);
      for (int i = 0; i < 4; i++)
         run_scan(IW'($urandom_range(0, 3)), DW'({$urandom, $urandom}),
                  IW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 1'b0);

      // reset in the middle of SHIFT
      d = DW'({$urandom, $urandom});
      cur_ir    = 2'd1;
      cmd_ir    = 2'd1;
      cmd_dr    = d;
      loop_mode = 1'b1;
      sdr_rises = 0;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      k = 0;
      while (sdr_rises < 17 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("reach_bit17", 64'(sdr_rises), 64'(17));
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ctl", 64'({busy, rsp_valid, vji_tck, vji_tdi, strb}), 64'(0));
      chk("abort_ready", 64'(cmd_ready), 64'(1));
      reset = 1'b0;
      err = 0;
      repeat (300) begin
         @(negedge clk);
         if (rsp_valid || busy) err++;
      end
      chk("no_rsp_after_abort", 64'(err), 64'(0));

      // command coinciding with reset is dropped
      reset     = 1'b1;
      cmd_valid = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("cmd_with_reset", 64'({busy, vji_uir}), 64'(0));

      run_scan(2'd3, DW'({$urandom, $urandom}), 2'b10, 1'b0, 2, 1'b0);

      // back-to-back with cmd_valid held high
      run_scan(2'd0, DW'({$urandom, $urandom}), 2'b01, 1'b1, 0, 1'b1);
      run_scan(2'd2, DW'({$urandom, $urandom}), 2'b10, 1'b0, 0, 1'b0);
      chk("b2b_gap", 64'(acc_gap), 64'(1 + (DW + 4) * 4 + 1));

      // TCK_DIV=1 instance, tdo tied high
      cmd_ir1    = 2'd1;
      cmd_dr1    = DW'({$urandom, $urandom});
      cmd_valid1 = 1'b1;
      @(negedge clk);
      cmd_valid1 = 1'b0;
      k = 1;
      err = 0;
      while (!rsp_valid1 && k < 400) begin
         if (vji_tck1 != ((k % 2) == 0)) err++;
         @(negedge clk);
         k++;
      end
      chk("div1_latency", 64'(k), 64'(1 + (DW + 4) * 2));
      chk("div1_toggle", 64'(err), 64'(0));
      chk("div1_rsp_dr", 64'(rsp_dr1), 64'({DW{1'b1}}));
      rsp_ready1 = 1'b1;
      @(negedge clk);
      rsp_ready1 = 1'b0;
      chk("div1_idle", 64'({cmd_ready1, busy1}), 64'(2'b10));

      chk("monitor", 64'(mon_err), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
